// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer guarding one shared WIDTH-bit register.
// Optional locked-burst tenure is compiled in with SHARED_REG_LOCK_EN.
module shared_reg_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [2:0]            owner,
  output logic                  busy
);

  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t            state, state_nx;
  logic [NREQ-1:0]   gnt_nx, ack_nx;
  logic [WIDTH-1:0]  q_nx, owner_data;
  logic [OW-1:0]     owner_nx, ptr, ptr_nx, winner, ptr_after;
  logic              busy_nx, found, owner_req;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int i = 0; i < int'(NREQ); i++) begin
      int j;
      j = (int'(ptr) + i) % int'(NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        winner = OW'(j);
      end
    end
  end

  // Per-owner views of the requester buses.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner == OW'(i)) owner_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign owner_req = |(req & (NREQ'(1) << owner));
  assign ptr_after = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

`ifdef SHARED_REG_LOCK_EN
  localparam int unsigned BW = $clog2(LOCK_MAX + 1);
  logic [BW-1:0] burst, burst_nx;
  logic          owner_lock;
  logic          hold;

  assign owner_lock = |(lock & (NREQ'(1) << owner));
  assign hold       = owner_lock && owner_req && (burst < BW'(LOCK_MAX - 1));
`else
  logic unused_lock;
  logic hold;

  assign unused_lock = ^{lock, LOCK_MAX};
  assign hold        = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ack_nx   = '0;
    q_nx     = q;
    owner_nx = owner;
    ptr_nx   = ptr;
`ifdef SHARED_REG_LOCK_EN
    burst_nx = burst;
`endif
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (found) begin
          state_nx = GRANT;
          gnt_nx   = NREQ'(1) << winner;
          owner_nx = winner;
        end
      end
      GRANT: begin
        if (owner_req) begin
          q_nx     = owner_data;
          ack_nx   = gnt;
          state_nx = ACK;
        end else begin
          gnt_nx   = '0;
          state_nx = IDLE;
`ifdef SHARED_REG_LOCK_EN
          burst_nx = '0;
`endif
        end
      end
      ACK: begin
        if (hold) begin
          state_nx = GRANT;
`ifdef SHARED_REG_LOCK_EN
          burst_nx = burst + BW'(1);
`endif
        end else begin
          gnt_nx   = '0;
          ptr_nx   = ptr_after;
          state_nx = IDLE;
`ifdef SHARED_REG_LOCK_EN
          burst_nx = '0;
`endif
        end
      end
      default: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
`ifdef SHARED_REG_LOCK_EN
      burst <= '0;
`endif
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      ack   <= ack_nx;
      q     <= q_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      busy  <= busy_nx;
`ifdef SHARED_REG_LOCK_EN
      burst <= burst_nx;
`endif
    end
  end

endmodule
